fpu_result_buffer: RTL

Elastic buffer between the floating-point coprocessor's XIF result output and the core's result input. Holds up to DEPTH completed results in issue order, so coprocessor writeback stalls do not back-pressure the FPU pipeline. Fully registered output: no combinational path from `in_valid_i` to `out_valid_o` or from `out_ready_i` to `in_ready_o`.

---
 rtl/fpu_ss_pkg.sv | 17 +
 rtl/fpu_result_buffer.sv | 106 ++++++++++
 2 files changed

// File: rtl/fpu_ss_pkg.sv
// Shared FPU subsystem types: XIF result record and buffer defaults.
package fpu_ss_pkg;

   localparam int unsigned FPU_RESULT_BUF_DEPTH = 4;
   localparam int unsigned FPU_ID_WIDTH         = 4;
   localparam int unsigned FPU_DATA_WIDTH       = 32;

   typedef struct packed {
      logic [FPU_ID_WIDTH-1:0]   id;
      logic [FPU_DATA_WIDTH-1:0] data;
      logic [4:0]                rd;
      logic                      we;
      logic [2:0]                ecswe;
      logic [5:0]                ecsdata;
   } result_t;

endpackage

// File: rtl/fpu_result_buffer.sv
// Registered FIFO between the FPU XIF result port and the core result input.
// Optional high-water-mark output enabled by FPU_RESULT_BUFFER_HWM_EN.
module fpu_result_buffer
   import fpu_ss_pkg::*;
#(
   parameter int unsigned DEPTH      = FPU_RESULT_BUF_DEPTH,
   parameter int unsigned ID_WIDTH   = FPU_ID_WIDTH,
   parameter int unsigned DATA_WIDTH = FPU_DATA_WIDTH
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  result_t                    in_result_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output result_t                    out_result_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
`ifdef FPU_RESULT_BUFFER_HWM_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] max_level_o
`endif
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = $clog2(DEPTH + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
   localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

   // The payload layout is fixed by the shared package; catch mismatched overrides.
   if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
      $error("fpu_result_buffer: DEPTH must be within 2..16");
   end
   if (ID_WIDTH != FPU_ID_WIDTH || DATA_WIDTH != FPU_DATA_WIDTH) begin : g_bad_width
      $error("fpu_result_buffer: ID_WIDTH/DATA_WIDTH must match fpu_ss_pkg");
   end

   result_t         mem_q [DEPTH];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [LvlW-1:0] level_q, level_d;
   logic            push, pop;

   assign in_ready_o   = (level_q != FullLvl);
   assign out_valid_o  = (level_q != '0);
   assign out_result_o = mem_q[rptr_q];
   assign level_o      = level_q;

   assign push = in_valid_i && in_ready_o;
   assign pop  = out_valid_o && out_ready_i;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (push) begin
         wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop) begin
         rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage is cleared on reset so the head reads as all-zero afterwards.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wptr_q] <= in_result_i;
      end
   end

`ifdef FPU_RESULT_BUFFER_HWM_EN
   logic [LvlW-1:0] max_level_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         max_level_q <= '0;
      end else if (level_d > max_level_q) begin
         max_level_q <= level_d;
      end
   end

   assign max_level_o = max_level_q;
`endif

endmodule
